ir_control_sequencer: RTL and testbench
=======================================

Name: ir_control_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller, directly downstream of the instruction register.
- Consumes the 32-bit instruction that the register drives out.
- Generates every datapath control line, including the register's own load (busc_in) and output-enable (instrn_out) strobes.
- Targets the three-bus datapath: bus A/B operands, bus C result.

Parameters:
- TIMEOUT_CYCLES, 255, memory-wait cycles before bus error (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- INSTRN_DATA_IN  in  32  instruction from instruction register output
- mem_ready  in  1  memory transfer complete, sampled on clk
- alu_zero  in  1  ALU result zero flag
- ir_busc_in  out  1  load instruction register from bus C
- ir_out  out  1  instruction register output enable
- pc_busa_out  out  1  PC drives bus A
- pc_inc  out  1  PC += 4
- pc_busc_in  out  1  PC loads from bus C
- mar_busc_in  out  1  MAR loads from bus C
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mdr_busc_out  out  1  MDR drives bus C
- rf_rd_a  out  5  register-file read address A
- rf_rd_b  out  5  register-file read address B
- rf_wr_addr  out  5  register-file write address
- rf_busa_out  out  1  register file drives bus A
- rf_busb_out  out  1  register file drives bus B
- rf_busc_in  out  1  register-file write from bus C
- imm_busb_out  out  1  immediate drives bus B
- imm_value  out  32  sign-extended INSTRN[15:0]
- alu_op  out  4  0=PASS_A, 1=PASS_B, 2=ADD, 3=SUB, 4=AND, 5=OR
- alu_busc_out  out  1  ALU drives bus C
- halted  out  1  sequencer stopped
- illegal_op  out  1  one-cycle pulse on undefined opcode
- bus_error  out  1  sticky memory timeout flag

Behaviour:
- Instruction fields:
  - opcode [31:26], rd [25:21], rs1 [20:16], rs2 [15:11], imm [15:0].
  - Latched into internal registers in DEC.
  - rf_* addresses and imm_value are driven from the latched fields, stable until the next DEC.
- Opcodes: ADD 000000, SUB 000001, AND 000010, OR 000011, ADDI 001000, LW 010000, SW 010001, BEQ 011000, JMP 011100, HALT 111111.
- Outputs are decoded from the state; only one bus-C driver is active per state.
- Reset:
  - Asynchronous; state=F0.
  - All strobes, alu_op, latched fields, halted, illegal_op and bus_error = 0.
  - Reset asserted mid-instruction aborts it; no mem_wr or rf_busc_in is issued after assertion.
- States and transitions:
  - F0: pc_busa_out, alu_op=PASS_A, alu_busc_out, mar_busc_in -> F1.
  - F1: mem_rd held; stays while mem_ready=0; -> F2 on the edge sampling mem_ready=1 (zero-wait memory gives 1 cycle).
  - F2: mdr_busc_out, ir_busc_in, pc_inc -> DEC.
  - DEC: ir_out=1; latch fields.
    - R-type -> EXR; ADDI -> EXI; LW/SW -> EXA; BEQ -> EXB; JMP -> EXJ; HALT -> HLT.
    - Undefined opcode: illegal_op pulses for 1 cycle, -> F0 (NOP).
  - EXR: rf_busa_out(rs1), rf_busb_out(rs2), alu_op per opcode, alu_busc_out, rf_busc_in(rd) -> F0.
  - EXI: rf_busa_out(rs1), imm_busb_out, ADD, alu_busc_out, rf_busc_in(rd) -> F0.
  - EXA: rs1+imm via ALU into MAR -> MRD (LW) or MWR (SW).
  - MRD: mem_rd held until mem_ready -> WB. WB: mdr_busc_out, rf_busc_in(rd) -> F0.
  - MWR: mem_wr held, rf_busb_out with rf_rd_b=rd as write data, until mem_ready -> F0.
  - EXB: rs1, rs2, SUB; alu_zero sampled this cycle; 1 -> BR, 0 -> F0.
  - BR: pc_busa_out, imm_busb_out, ADD, alu_busc_out, pc_busc_in -> F0. Offset is relative to the already-incremented PC.
  - EXJ: imm_busb_out, PASS_B, alu_busc_out, pc_busc_in -> F0.
  - HLT: halted=1, all strobes 0; exits only via reset.
- Cycle counts with zero-wait memory: R-type/ADDI 5, LW 7, SW 6, BEQ 5 (not taken) / 6 (taken), JMP 5.
- Register 0 receives no special treatment; the register file owns that rule.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 8..16-bit wait counter cleared on entry to F1/MRD/MWR.
  - If mem_ready stays low for TIMEOUT_CYCLES consecutive cycles, deassert mem_rd/mem_wr, set bus_error (sticky until reset), -> HLT.
- Undefined: waits indefinitely; bus_error tied 0.

Test Plan:
- Reset mid-F1 with mem_rd high -> all outputs 0 immediately, F0 strobes on the first clk after release.
- ADD rd=3, rs1=1, rs2=2, mem_ready always 1 -> DEC on cycle 4, EXR on cycle 5 with rf_rd_a=1, rf_rd_b=2, rf_wr_addr=3, alu_op=2, rf_busc_in=1; next cycle F0.
- LW rd=4, imm=0xFFFC, mem_ready delayed 3 cycles in MRD -> imm_value=0xFFFFFFFC; mem_rd high 4 cycles; WB writes rf_wr_addr=4.
- BEQ with alu_zero=1, then with alu_zero=0 -> BR asserts pc_busc_in (6 cycles) vs. return to F0 (5 cycles).
- Opcode 000111 -> illegal_op single-cycle pulse in DEC, no rf_busc_in, next fetch proceeds; HALT opcode -> halted=1 held for 100 cycles.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready stuck 0 in F1 -> bus_error=1 and halted=1 after 8 wait cycles; without the macro, mem_rd stays high.

Source files
------------

// File: rtl/ir_control_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the three-bus datapath.
// Optional MEM_TIMEOUT_EN adds a memory-wait watchdog that raises bus_error and halts.
module ir_control_sequencer
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] INSTRN_DATA_IN,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        ir_busc_in,
    output logic        ir_out,
    output logic        pc_busa_out,
    output logic        pc_inc,
    output logic        pc_busc_in,
    output logic        mar_busc_in,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mdr_busc_out,
    output logic [4:0]  rf_rd_a,
    output logic [4:0]  rf_rd_b,
    output logic [4:0]  rf_wr_addr,
    output logic        rf_busa_out,
    output logic        rf_busb_out,
    output logic        rf_busc_in,
    output logic        imm_busb_out,
    output logic [31:0] imm_value,
    output logic [3:0]  alu_op,
    output logic        alu_busc_out,
    output logic        halted,
    output logic        illegal_op,
    output logic        bus_error
);

    typedef enum logic [3:0] {
        StF0, StF1, StF2, StDec, StExr, StExi, StExa, StMrd,
        StWb, StMwr, StExb, StBr, StExj, StHlt
    } state_e;

    localparam logic [5:0] OpAdd  = 6'b000000;
    localparam logic [5:0] OpSub  = 6'b000001;
    localparam logic [5:0] OpAnd  = 6'b000010;
    localparam logic [5:0] OpOr   = 6'b000011;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpLw   = 6'b010000;
    localparam logic [5:0] OpSw   = 6'b010001;
    localparam logic [5:0] OpBeq  = 6'b011000;
    localparam logic [5:0] OpJmp  = 6'b011100;
    localparam logic [5:0] OpHalt = 6'b111111;

    localparam logic [3:0] AluPassA = 4'd0;
    localparam logic [3:0] AluPassB = 4'd1;
    localparam logic [3:0] AluAdd   = 4'd2;
    localparam logic [3:0] AluSub   = 4'd3;
    localparam logic [3:0] AluAnd   = 4'd4;
    localparam logic [3:0] AluOr    = 4'd5;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_started;
    logic [5:0]  r_opcode;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [15:0] r_imm;
    logic [4:0]  r_rf_rd_b;

    logic        r_ir_busc_in, r_ir_out, r_pc_busa_out, r_pc_inc, r_pc_busc_in;
    logic        r_mar_busc_in, r_mem_rd, r_mem_wr, r_mdr_busc_out;
    logic        r_rf_busa_out, r_rf_busb_out, r_rf_busc_in, r_imm_busb_out;
    logic        r_alu_busc_out, r_halted;
    logic [3:0]  r_alu_op;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs2_cur;
    logic        w_legal;
    logic [3:0]  w_alu_r;
    logic        w_timeout;

    assign w_opcode  = INSTRN_DATA_IN[31:26];
    assign w_rs2_cur = (r_state == StDec) ? INSTRN_DATA_IN[15:11] : r_rs2;

    always_comb begin
        w_legal = 1'b0;
        w_alu_r = AluAdd;
        case (w_opcode)
            OpAdd, OpAddi, OpLw, OpSw, OpBeq, OpJmp, OpHalt: w_legal = 1'b1;
            OpSub: begin w_legal = 1'b1; w_alu_r = AluSub; end
            OpAnd: begin w_legal = 1'b1; w_alu_r = AluAnd; end
            OpOr:  begin w_legal = 1'b1; w_alu_r = AluOr;  end
            default: ;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_bus_error;
    logic        w_waiting;

    assign w_waiting = (r_state == StF1) || (r_state == StMrd) || (r_state == StMwr);
    assign w_timeout = w_waiting && !mem_ready &&
                       (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Counter restarts whenever a wait state is (re)entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt  <= '0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_wait_cnt <= '0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    assign bus_error = r_bus_error;
`else
    assign w_timeout = 1'b0;
    assign bus_error = 1'b0;
`endif

    // r_started holds F0 for one cycle after reset so its strobes appear on the first edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StF0:  w_state_next = r_started ? StF1 : StF0;
            StF1:  if (mem_ready) w_state_next = StF2;
            StF2:  w_state_next = StDec;
            StDec: begin
                case (w_opcode)
                    OpAdd, OpSub, OpAnd, OpOr: w_state_next = StExr;
                    OpAddi:                    w_state_next = StExi;
                    OpLw, OpSw:                w_state_next = StExa;
                    OpBeq:                     w_state_next = StExb;
                    OpJmp:                     w_state_next = StExj;
                    OpHalt:                    w_state_next = StHlt;
                    default:                   w_state_next = StF0;
                endcase
            end
            StExa: w_state_next = (r_opcode == OpLw) ? StMrd : StMwr;
            StMrd: if (mem_ready) w_state_next = StWb;
            StMwr: if (mem_ready) w_state_next = StF0;
            StExb: w_state_next = alu_zero ? StBr : StF0;
            StHlt: w_state_next = StHlt;
            default: w_state_next = StF0;
        endcase
        if (w_timeout) begin
            w_state_next = StHlt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= StF0;
            r_started      <= 1'b0;
            r_opcode       <= '0;
            r_rd           <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_imm          <= '0;
            r_rf_rd_b      <= '0;
            r_ir_busc_in   <= 1'b0;
            r_ir_out       <= 1'b0;
            r_pc_busa_out  <= 1'b0;
            r_pc_inc       <= 1'b0;
            r_pc_busc_in   <= 1'b0;
            r_mar_busc_in  <= 1'b0;
            r_mem_rd       <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mdr_busc_out <= 1'b0;
            r_rf_busa_out  <= 1'b0;
            r_rf_busb_out  <= 1'b0;
            r_rf_busc_in   <= 1'b0;
            r_imm_busb_out <= 1'b0;
            r_alu_busc_out <= 1'b0;
            r_alu_op       <= AluPassA;
            r_halted       <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_started <= 1'b1;
            if (r_state == StDec) begin
                r_opcode <= w_opcode;
                r_rd     <= INSTRN_DATA_IN[25:21];
                r_rs1    <= INSTRN_DATA_IN[20:16];
                r_rs2    <= INSTRN_DATA_IN[15:11];
                r_imm    <= INSTRN_DATA_IN[15:0];
            end
            // Stores read their write data through port B, addressed by rd.
            r_rf_rd_b <= (w_state_next == StMwr) ? r_rd : w_rs2_cur;

            r_ir_busc_in   <= 1'b0;
            r_ir_out       <= 1'b0;
            r_pc_busa_out  <= 1'b0;
            r_pc_inc       <= 1'b0;
            r_pc_busc_in   <= 1'b0;
            r_mar_busc_in  <= 1'b0;
            r_mem_rd       <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mdr_busc_out <= 1'b0;
            r_rf_busa_out  <= 1'b0;
            r_rf_busb_out  <= 1'b0;
            r_rf_busc_in   <= 1'b0;
            r_imm_busb_out <= 1'b0;
            r_alu_busc_out <= 1'b0;
            r_alu_op       <= AluPassA;
            r_halted       <= (w_state_next == StHlt);

            case (w_state_next)
                StF0: begin
                    r_pc_busa_out  <= 1'b1;
                    r_alu_busc_out <= 1'b1;
                    r_mar_busc_in  <= 1'b1;
                end
                StF1, StMrd: r_mem_rd <= 1'b1;
                StF2: begin
                    r_mdr_busc_out <= 1'b1;
                    r_ir_busc_in   <= 1'b1;
                    r_pc_inc       <= 1'b1;
                end
                StDec: r_ir_out <= 1'b1;
                StExr: begin
                    r_rf_busa_out  <= 1'b1;
                    r_rf_busb_out  <= 1'b1;
                    r_alu_op       <= w_alu_r;
                    r_alu_busc_out <= 1'b1;
                    r_rf_busc_in   <= 1'b1;
                end
                StExi: begin
                    r_rf_busa_out  <= 1'b1;
                    r_imm_busb_out <= 1'b1;
                    r_alu_op       <= AluAdd;
                    r_alu_busc_out <= 1'b1;
                    r_rf_busc_in   <= 1'b1;
                end
                StExa: begin
                    r_rf_busa_out  <= 1'b1;
                    r_imm_busb_out <= 1'b1;
                    r_alu_op       <= AluAdd;
                    r_alu_busc_out <= 1'b1;
                    r_mar_busc_in  <= 1'b1;
                end
                StWb: begin
                    r_mdr_busc_out <= 1'b1;
                    r_rf_busc_in   <= 1'b1;
                end
                StMwr: begin
                    r_mem_wr      <= 1'b1;
                    r_rf_busb_out <= 1'b1;
                end
                StExb: begin
                    r_rf_busa_out <= 1'b1;
                    r_rf_busb_out <= 1'b1;
                    r_alu_op      <= AluSub;
                end
                StBr: begin
                    r_pc_busa_out  <= 1'b1;
                    r_imm_busb_out <= 1'b1;
                    r_alu_op       <= AluAdd;
                    r_alu_busc_out <= 1'b1;
                    r_pc_busc_in   <= 1'b1;
                end
                StExj: begin
                    r_imm_busb_out <= 1'b1;
                    r_alu_op       <= AluPassB;
                    r_alu_busc_out <= 1'b1;
                    r_pc_busc_in   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ir_busc_in   = r_ir_busc_in;
    assign ir_out       = r_ir_out;
    assign pc_busa_out  = r_pc_busa_out;
    assign pc_inc       = r_pc_inc;
    assign pc_busc_in   = r_pc_busc_in;
    assign mar_busc_in  = r_mar_busc_in;
    assign mem_rd       = r_mem_rd;
    assign mem_wr       = r_mem_wr;
    assign mdr_busc_out = r_mdr_busc_out;
    assign rf_rd_a      = r_rs1;
    assign rf_rd_b      = r_rf_rd_b;
    assign rf_wr_addr   = r_rd;
    assign rf_busa_out  = r_rf_busa_out;
    assign rf_busb_out  = r_rf_busb_out;
    assign rf_busc_in   = r_rf_busc_in;
    assign imm_busb_out = r_imm_busb_out;
    assign imm_value    = {{16{r_imm[15]}}, r_imm};
    assign alu_op       = r_alu_op;
    assign alu_busc_out = r_alu_busc_out;
    assign halted       = r_halted;
    // Decode-time flag straight off the IR output, visible during DEC itself.
    assign illegal_op   = (r_state == StDec) && !w_legal;

endmodule

// File: tb/tb_ir_control_sequencer.sv
// Bench for ir_control_sequencer: per-instruction cycle schedule model plus literal pins.
// Build with MEM_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT_CYCLES=8).
module tb_ir_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;

    logic ir_busc_in, ir_out, pc_busa_out, pc_inc, pc_busc_in, mar_busc_in;
    logic mem_rd, mem_wr, mdr_busc_out, rf_busa_out, rf_busb_out, rf_busc_in;
    logic imm_busb_out, alu_busc_out, halted, illegal_op, bus_error;
    logic [4:0]  rf_rd_a, rf_rd_b, rf_wr_addr;
    logic [31:0] imm_value;
    logic [3:0]  alu_op;

`ifdef MEM_TIMEOUT_EN
    ir_control_sequencer #(.TIMEOUT_CYCLES(8)) dut (
`else
    ir_control_sequencer dut (
`endif
        .clk(clk), .reset(reset), .INSTRN_DATA_IN(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .ir_busc_in(ir_busc_in), .ir_out(ir_out),
        .pc_busa_out(pc_busa_out), .pc_inc(pc_inc), .pc_busc_in(pc_busc_in),
        .mar_busc_in(mar_busc_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mdr_busc_out(mdr_busc_out), .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
        .rf_wr_addr(rf_wr_addr), .rf_busa_out(rf_busa_out), .rf_busb_out(rf_busb_out),
        .rf_busc_in(rf_busc_in), .imm_busb_out(imm_busb_out), .imm_value(imm_value),
        .alu_op(alu_op), .alu_busc_out(alu_busc_out), .halted(halted),
        .illegal_op(illegal_op), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ir_busc_in, ir_out, pc_busa_out, pc_inc, pc_busc_in, mar_busc_in;
        logic mem_rd, mem_wr, mdr_busc_out, rf_busa_out, rf_busb_out, rf_busc_in;
        logic imm_busb_out, alu_busc_out, halted, illegal_op, bus_error;
        logic [3:0]  alu_op;
        logic [4:0]  rf_rd_a, rf_rd_b, rf_wr_addr;
        logic [31:0] imm_value;
    } ctl_t;

    typedef struct packed {
        logic [31:0] ins;
        logic        rdy;
        logic        z;
        ctl_t        e;
    } step_t;

    ctl_t  act;
    step_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    step_no = 0;
    logic [4:0]  m_rd = '0, m_rs1 = '0, m_rs2 = '0;
    logic [15:0] m_imm = '0;

    assign act = {ir_busc_in, ir_out, pc_busa_out, pc_inc, pc_busc_in, mar_busc_in,
                  mem_rd, mem_wr, mdr_busc_out, rf_busa_out, rf_busb_out, rf_busc_in,
                  imm_busb_out, alu_busc_out, halted, illegal_op, bus_error,
                  alu_op, rf_rd_a, rf_rd_b, rf_wr_addr, imm_value};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'd0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    // Baseline vector: no strobes, addresses/immediate from the last decoded instruction.
    function automatic ctl_t mk();
        ctl_t e = '0;
        e.rf_rd_a    = m_rs1;
        e.rf_rd_b    = m_rs2;
        e.rf_wr_addr = m_rd;
        e.imm_value  = {{16{m_imm[15]}}, m_imm};
        return e;
    endfunction

    task automatic push(input logic [31:0] ins, input ctl_t e, input logic rdy, input logic z);
        step_t s;
        s.ins = ins; s.rdy = rdy; s.z = z; s.e = e;
        q.push_back(s);
    endtask

    // Expected per-cycle schedule for one instruction given its memory waits and branch flag.
    task automatic gen(input logic [31:0] ins, input int f1w, input int mw, input logic z);
        ctl_t e;
        logic [5:0] op = ins[31:26];
        e = mk(); e.pc_busa_out = 1; e.alu_busc_out = 1; e.mar_busc_in = 1;
        push(ins, e, 1'b1, 1'b0);
        for (int i = 0; i <= f1w; i++) begin
            e = mk(); e.mem_rd = 1; push(ins, e, (i == f1w), 1'b0);
        end
        e = mk(); e.mdr_busc_out = 1; e.ir_busc_in = 1; e.pc_inc = 1;
        push(ins, e, 1'b1, 1'b0);
        e = mk(); e.ir_out = 1;
        e.illegal_op = !(op inside {6'o00, 6'o01, 6'o02, 6'o03, 6'o10, 6'o20, 6'o21,
                                    6'o30, 6'o34, 6'o77});
        push(ins, e, 1'b1, 1'b0);
        m_rd = ins[25:21]; m_rs1 = ins[20:16]; m_rs2 = ins[15:11]; m_imm = ins[15:0];
        e = mk();
        case (op)
            6'o00, 6'o01, 6'o02, 6'o03: begin
                e.rf_busa_out = 1; e.rf_busb_out = 1; e.alu_busc_out = 1; e.rf_busc_in = 1;
                e.alu_op = 4'd2 + 4'(op);
                push(ins, e, 1'b1, 1'b0);
            end
            6'o10: begin
                e.rf_busa_out = 1; e.imm_busb_out = 1; e.alu_op = 2;
                e.alu_busc_out = 1; e.rf_busc_in = 1;
                push(ins, e, 1'b1, 1'b0);
            end
            6'o20, 6'o21: begin
                e.rf_busa_out = 1; e.imm_busb_out = 1; e.alu_op = 2;
                e.alu_busc_out = 1; e.mar_busc_in = 1;
                push(ins, e, 1'b1, 1'b0);
                for (int i = 0; i <= mw; i++) begin
                    e = mk();
                    if (op == 6'o20) e.mem_rd = 1;
                    else begin e.mem_wr = 1; e.rf_busb_out = 1; e.rf_rd_b = m_rd; end
                    push(ins, e, (i == mw), 1'b0);
                end
                if (op == 6'o20) begin
                    e = mk(); e.mdr_busc_out = 1; e.rf_busc_in = 1;
                    push(ins, e, 1'b1, 1'b0);
                end
            end
            6'o30: begin
                e.rf_busa_out = 1; e.rf_busb_out = 1; e.alu_op = 3;
                push(ins, e, 1'b1, z);
                if (z) begin
                    e = mk(); e.pc_busa_out = 1; e.imm_busb_out = 1; e.alu_op = 2;
                    e.alu_busc_out = 1; e.pc_busc_in = 1;
                    push(ins, e, 1'b1, 1'b0);
                end
            end
            6'o34: begin
                e.imm_busb_out = 1; e.alu_op = 1; e.alu_busc_out = 1; e.pc_busc_in = 1;
                push(ins, e, 1'b1, 1'b0);
            end
            6'o77: begin
                e.halted = 1;
                for (int i = 0; i < 100; i++) push(ins, e, 1'b0, 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            step_t s;
            if (q.size() == 0) break;
            s = q.pop_front();
            @(negedge clk);
            chk($sformatf("step%0d", step_no), 128'(act), 128'(s.e));
            chk("single_busc_driver", 128'(alu_busc_out & mdr_busc_out), 128'(0));
            step_no++;
            instr = s.ins; mem_ready = s.rdy; alu_zero = s.z;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
    endtask

    // Caller is at a negedge; reset is released on the following negedge.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1 chk("async_reset_zero", 128'(act), 128'(0));
        model_reset();
        @(negedge clk);
        chk("reset_hold_zero", 128'(act), 128'(0));
        reset = 1'b0;
    endtask

    initial begin
        ctl_t e;
        repeat (2) @(negedge clk);
        chk("reset_outputs_zero", 128'(act), 128'(0));
        reset = 1'b0;

        // Abort an instruction while F1 is waiting with mem_rd high.
        gen(r_ins(6'o00, 5'd3, 5'd1, 5'd2), 5, 0, 1'b0);
        play(3);
        chk("mid_f1_mem_rd", 128'(mem_rd), 128'(1));
        apply_reset();

        gen(r_ins(6'o00, 5'd3, 5'd1, 5'd2), 0, 0, 1'b0);
        chk("add_len", 128'(q.size()), 128'(5));
        play(1);
        chk("f0_after_release", 128'({pc_busa_out, alu_busc_out, mar_busc_in, alu_op}),
            128'(8'h70));
        play(4);
        chk("add_rf_rd_a", 128'(rf_rd_a), 128'(1));
        chk("add_rf_rd_b", 128'(rf_rd_b), 128'(2));
        chk("add_rf_wr_addr", 128'(rf_wr_addr), 128'(3));
        chk("add_alu_op", 128'(alu_op), 128'(2));
        chk("add_rf_busc_in", 128'(rf_busc_in), 128'(1));

        gen(r_ins(6'o01, 5'd5, 5'd6, 5'd7), 2, 0, 1'b0);
        play(q.size());
        gen(r_ins(6'o02, 5'd8, 5'd9, 5'd10), 0, 0, 1'b0);
        play(q.size());
        gen(r_ins(6'o03, 5'd11, 5'd12, 5'd13), 0, 0, 1'b0);
        play(4);
        play(1);
        chk("or_alu_op", 128'(alu_op), 128'(5));
        gen(i_ins(6'o10, 5'd14, 5'd15, 16'h8001), 0, 0, 1'b0);
        play(q.size());
        chk("addi_imm_sext", 128'(imm_value), 128'(32'hFFFF8001));

        gen(i_ins(6'o20, 5'd4, 5'd5, 16'hFFFC), 0, 3, 1'b0);
        chk("lw_len", 128'(q.size()), 128'(10));
        play(9);
        play(1);
        chk("lw_imm_value", 128'(imm_value), 128'(32'hFFFFFFFC));
        chk("lw_wb_addr", 128'(rf_wr_addr), 128'(4));
        chk("lw_wb_strobes", 128'({mdr_busc_out, rf_busc_in}), 128'(2'b11));

        gen(i_ins(6'o21, 5'd7, 5'd2, 16'h0008), 0, 1, 1'b0);
        play(6);
        chk("sw_data_addr", 128'(rf_rd_b), 128'(7));
        chk("sw_mem_wr", 128'(mem_wr), 128'(1));
        play(q.size());

        gen(r_ins(6'o30, 5'd0, 5'd1, 5'd1) | 32'h10, 0, 0, 1'b1);
        chk("beq_taken_len", 128'(q.size()), 128'(6));
        play(q.size());
        chk("beq_taken_pc_load", 128'(pc_busc_in), 128'(1));
        gen(r_ins(6'o30, 5'd0, 5'd1, 5'd2), 0, 0, 1'b0);
        chk("beq_not_taken_len", 128'(q.size()), 128'(5));
        play(q.size());

        gen(i_ins(6'o34, 5'd0, 5'd0, 16'h0040), 0, 0, 1'b0);
        play(q.size());

        gen(r_ins(6'o07, 5'd9, 5'd1, 5'd2), 0, 0, 1'b0);
        play(4);
        chk("illegal_pulse", 128'(illegal_op), 128'(1));
        gen(r_ins(6'o00, 5'd1, 5'd2, 5'd3), 0, 0, 1'b0);
        play(q.size());

        gen(32'hFC00_0000, 1, 0, 1'b0);
        play(q.size());
        chk("halt_held", 128'(halted), 128'(1));

        apply_reset();
        e = mk(); e.pc_busa_out = 1; e.alu_busc_out = 1; e.mar_busc_in = 1;
        push(32'd0, e, 1'b0, 1'b0);
`ifdef MEM_TIMEOUT_EN
        e = mk(); e.mem_rd = 1;
        for (int i = 0; i < 8; i++) push(32'd0, e, 1'b0, 1'b0);
        e = mk(); e.halted = 1; e.bus_error = 1;
        for (int i = 0; i < 20; i++) push(32'd0, e, 1'b0, 1'b0);
        play(q.size());
        chk("timeout_bus_error", 128'({bus_error, halted, mem_rd}), 128'(3'b110));
`else
        e = mk(); e.mem_rd = 1;
        for (int i = 0; i < 40; i++) push(32'd0, e, 1'b0, 1'b0);
        play(q.size());
        chk("no_timeout_wait", 128'({bus_error, halted, mem_rd}), 128'(3'b001));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
